// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG coil bank: channel state encoding,
// default angle-counter geometry and the angle range check.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SET = 2'd1,
    DWELL    = 2'd2
  } ch_state_e;

  localparam int ACNT_TOP_DEF   = 3839;
  localparam int ACNT_WIDTH_DEF = 24;

  function automatic logic angle_in_range(input logic [63:0] angle, input logic [63:0] top);
    return (angle <= top);
  endfunction

endpackage

// File: rtl/hwag_coil_bank_if.sv
// Shadow-register write bus of the coil bank; the writer holds the master
// modport, the bank holds the slave modport and answers with wr_err.
interface hwag_coil_bank_if
  import hwag_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  wr_ena;
  logic [CH_W-1:0]       wr_ch;
  logic [ACNT_WIDTH-1:0] wr_set;
  logic [ACNT_WIDTH-1:0] wr_reset;
  logic                  wr_err;

  modport master (output wr_ena, output wr_ch, output wr_set, output wr_reset, input wr_err);
  modport slave  (input wr_ena, input wr_ch, input wr_set, input wr_reset, output wr_err);

endinterface

// File: rtl/hwag_coil_channel.sv
// One coil channel: shadow/active angle pair, IDLE/WAIT_SET/DWELL sequencer and,
// with HWAG_DWELL_LIMIT_EN, a dwell timer that cuts long dwells and flags overrun.
module hwag_coil_channel
  import hwag_pkg::*;
#(
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int TMR_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic                  ch_ena,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  acnt_step,
  input  logic                  wr_load,
  input  logic [ACNT_WIDTH-1:0] wr_set,
  input  logic [ACNT_WIDTH-1:0] wr_reset,
`ifdef HWAG_DWELL_LIMIT_EN
  input  logic [TMR_WIDTH-1:0]  dwell_max,
`endif
  output logic                  coil_out,
  output logic                  pending,
  output logic                  overrun
);

  ch_state_e             state_q, state_d;
  logic [ACNT_WIDTH-1:0] shd_set_q, shd_set_d, shd_rst_q, shd_rst_d;
  logic [ACNT_WIDTH-1:0] act_set_q, act_set_d, act_rst_q, act_rst_d;
  logic                  pending_q, pending_d, coil_q, coil_d;
  logic                  commit_s, hit_set_s, hit_rst_s, expire_s;
  logic [ACNT_WIDTH-1:0] eff_set_s, eff_rst_s;

`ifdef HWAG_DWELL_LIMIT_EN
  logic [TMR_WIDTH-1:0] timer_q, timer_d;
  logic                 overrun_q, overrun_d;

  // Limit check: a zero dwell_max disables the cut.
  always_comb begin
    expire_s = (dwell_max != {TMR_WIDTH{1'b0}}) && (timer_q == dwell_max);
  end
`else
  assign expire_s = 1'b0;
`endif

  // Commit happens outside DWELL; the set compare in a commit cycle sees the new angles.
  always_comb begin
    commit_s  = acnt_step && pending_q && (state_q != DWELL);
    eff_set_s = act_set_q;
    eff_rst_s = act_rst_q;
    if (commit_s) begin
      eff_set_s = shd_set_q;
      eff_rst_s = shd_rst_q;
    end else begin
      eff_set_s = act_set_q;
      eff_rst_s = act_rst_q;
    end
    hit_set_s = acnt_step && (acnt == eff_set_s) && (eff_set_s != eff_rst_s);
    hit_rst_s = acnt_step && (acnt == act_rst_q);
  end

  // Next-state, register loads and the registered coil drive.
  always_comb begin
    state_d   = state_q;
    shd_set_d = shd_set_q;
    shd_rst_d = shd_rst_q;
    act_set_d = eff_set_s;
    act_rst_d = eff_rst_s;
    pending_d = pending_q;

    if (wr_load) begin
      shd_set_d = wr_set;
      shd_rst_d = wr_reset;
      pending_d = 1'b1;
    end else if (commit_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (!hwag_start || !ch_ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = WAIT_SET;
        WAIT_SET: begin
          if (hit_set_s) state_d = DWELL;
          else           state_d = WAIT_SET;
        end
        DWELL: begin
          if (hit_rst_s || expire_s) state_d = WAIT_SET;
          else                       state_d = DWELL;
        end
        default:  state_d = IDLE;
      endcase
    end

    coil_d = (state_d == DWELL);
  end

`ifdef HWAG_DWELL_LIMIT_EN
  // Timer restarts on DWELL entry; overrun only when the limit, not the reset angle, ends it.
  always_comb begin
    if ((state_q == DWELL) && (state_d == DWELL)) begin
      timer_d = timer_q + TMR_WIDTH'(1);
    end else begin
      timer_d = {TMR_WIDTH{1'b0}};
    end
    overrun_d = (state_q == DWELL) && hwag_start && ch_ena && !hit_rst_s && expire_s;
  end

  // Dwell timer and overrun pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= {TMR_WIDTH{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // Channel state and angle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shd_set_q <= {ACNT_WIDTH{1'b0}};
      shd_rst_q <= {ACNT_WIDTH{1'b0}};
      act_set_q <= {ACNT_WIDTH{1'b0}};
      act_rst_q <= {ACNT_WIDTH{1'b0}};
      pending_q <= 1'b0;
      coil_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shd_set_q <= shd_set_d;
      shd_rst_q <= shd_rst_d;
      act_set_q <= act_set_d;
      act_rst_q <= act_rst_d;
      pending_q <= pending_d;
      coil_q    <= coil_d;
    end
  end

  assign coil_out = coil_q;
  assign pending  = pending_q;

endmodule

// File: rtl/hwag_coil_bank.sv
// N-channel ignition coil scheduler on the HWAG angle counter. The top decodes and
// range-checks shadow writes; HWAG_DWELL_LIMIT_EN adds dwell_max and overrun.
module hwag_coil_bank
  import hwag_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int ACNT_TOP   = ACNT_TOP_DEF,
  parameter int TMR_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  acnt_step,
  input  logic [CHANNELS-1:0]   ch_ena,
  hwag_coil_bank_if.slave       wr_bus,
`ifdef HWAG_DWELL_LIMIT_EN
  input  logic [TMR_WIDTH-1:0]  dwell_max,
`endif
  output logic [CHANNELS-1:0]   coil_out,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overrun
);

  logic                wr_ok_s, wr_err_d, wr_err_q;
  logic [CHANNELS-1:0] wr_load_s;

  // Accept a write only when the channel exists and both angles are on the wheel.
  always_comb begin
    wr_ok_s   = 1'b0;
    wr_err_d  = 1'b0;
    wr_load_s = {CHANNELS{1'b0}};
    if (wr_bus.wr_ena) begin
      wr_ok_s  = (32'(wr_bus.wr_ch) < 32'(CHANNELS))
              && angle_in_range(64'(wr_bus.wr_set), 64'(ACNT_TOP))
              && angle_in_range(64'(wr_bus.wr_reset), 64'(ACNT_TOP));
      wr_err_d = !wr_ok_s;
    end else begin
      wr_ok_s  = 1'b0;
      wr_err_d = 1'b0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_ok_s && (32'(wr_bus.wr_ch) == 32'(i))) wr_load_s[i] = 1'b1;
      else                                          wr_load_s[i] = 1'b0;
    end
  end

  // Rejected-write pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end

  assign wr_bus.wr_err = wr_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    hwag_coil_channel #(
      .ACNT_WIDTH (ACNT_WIDTH),
      .TMR_WIDTH  (TMR_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .ch_ena     (ch_ena[i]),
      .acnt       (acnt),
      .acnt_step  (acnt_step),
      .wr_load    (wr_load_s[i]),
      .wr_set     (wr_bus.wr_set),
      .wr_reset   (wr_bus.wr_reset),
`ifdef HWAG_DWELL_LIMIT_EN
      .dwell_max  (dwell_max),
`endif
      .coil_out   (coil_out[i]),
      .pending    (pending[i]),
      .overrun    (overrun[i])
    );
  end

endmodule

// File: tb/tb_hwag_coil_bank.sv
// Scoreboard bench for hwag_coil_bank: stimulus queues hand-computed output vectors
// with their arrival cycle, a monitor compares every observed output change.
module tb_hwag_coil_bank;
  import hwag_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int TOP = 3839;
  localparam int TW  = 24;
  localparam logic [12:0] ERR_M = 13'h100;

  logic           clk = 1'b0;
  logic           rst;
  logic           hwag_start;
  logic [AW-1:0]  acnt;
  logic           acnt_step;
  logic [NCH-1:0] ch_ena;
  logic [NCH-1:0] coil_out, pending, overrun;
`ifdef HWAG_DWELL_LIMIT_EN
  logic [TW-1:0]  dwell_max;
`endif

  hwag_coil_bank_if #(.CHANNELS(NCH), .ACNT_WIDTH(AW)) wr_bus ();

  hwag_coil_bank #(.CHANNELS(NCH), .ACNT_WIDTH(AW), .ACNT_TOP(TOP), .TMR_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt       (acnt),
    .acnt_step  (acnt_step),
    .ch_ena     (ch_ena),
    .wr_bus     (wr_bus.slave),
`ifdef HWAG_DWELL_LIMIT_EN
    .dwell_max  (dwell_max),
`endif
    .coil_out   (coil_out),
    .pending    (pending),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [12:0] v; } exp_t;
  typedef struct { int a; logic [12:0] v; } mark_t;
  exp_t  exp_q[$];
  mark_t marks[$];
  exp_t  mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [12:0] prev_v = 13'h0;
  logic [12:0] obs;

  assign obs = {overrun, wr_bus.wr_err, pending, coil_out};

  function automatic logic [12:0] mkv(input logic [3:0] ovr, input logic err,
                                      input logic [3:0] pend, input logic [3:0] coil);
    return {ovr, err, pend, coil};
  endfunction

  task automatic expect_at(input int c, input logic [12:0] v);
    exp_t e;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].c == c) begin
      exp_q[exp_q.size()-1].v = v;
    end else begin
      e.c = c;
      e.v = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic mark(input int a, input logic [12:0] v);
    mark_t m;
    m.a = a;
    m.v = v;
    marks.push_back(m);
  endtask

  task automatic step(input int a);
    int k;
    @(negedge clk);
    acnt      = AW'(a);
    acnt_step = 1'b1;
    k         = cyc;
    if (marks.size() > 0 && marks[0].a == a) begin
      expect_at(k + 1, marks[0].v);
      void'(marks.pop_front());
    end
    @(negedge clk);
    acnt_step = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(input int from, input int n);
    int a;
    a = from;
    for (int i = 0; i < n; i++) begin
      step(a);
      a = (a == TOP) ? 0 : a + 1;
    end
  endtask

  task automatic wr(input int ch, input int s, input int r, input logic [12:0] v);
    int k;
    @(negedge clk);
    wr_bus.wr_ena   = 1'b1;
    wr_bus.wr_ch    = 2'(ch);
    wr_bus.wr_set   = AW'(s);
    wr_bus.wr_reset = AW'(r);
    k = cyc;
    expect_at(k + 1, v);
    if (v[8]) expect_at(k + 2, v & ~ERR_M);
    @(negedge clk);
    wr_bus.wr_ena = 1'b0;
  endtask

  // Monitor: every change of the observed output vector must match the next expectation.
  always @(negedge clk) begin
    if (!rst && obs !== prev_v) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change got v=%h @%0d, nothing expected", obs, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.v !== obs || mon_e.c != cyc) begin
          n_fail++;
          $display("FAIL output_event got v=%h @%0d, required v=%h @%0d", obs, cyc, mon_e.v, mon_e.c);
        end
      end
      prev_v = obs;
    end
  end

  initial begin
    int k;
    rst = 1'b1; hwag_start = 1'b0; acnt = '0; acnt_step = 1'b0; ch_ena = '0;
    wr_bus.wr_ena = 1'b0; wr_bus.wr_ch = '0; wr_bus.wr_set = '0; wr_bus.wr_reset = '0;
`ifdef HWAG_DWELL_LIMIT_EN
    dwell_max = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%h, required v=%h", obs, 13'h0);
    end

    // ch0 100..200 and ch1 3800..50 across the wrap
    hwag_start = 1'b1;
    ch_ena     = 4'b0011;
    wr(0, 100, 200, mkv(4'b0, 1'b0, 4'b0001, 4'b0000));
    wr(1, 3800, 50, mkv(4'b0, 1'b0, 4'b0011, 4'b0000));
    mark(0,    mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(100,  mkv(4'b0, 1'b0, 4'b0000, 4'b0001));
    mark(200,  mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(3800, mkv(4'b0, 1'b0, 4'b0000, 4'b0010));
    mark(50,   mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(0, TOP + 1 + 61);

    // ch2: rewrite during dwell, commit deferred until after the reset angle
    @(negedge clk); ch_ena = 4'b0100;
    wr(2, 100, 300, mkv(4'b0, 1'b0, 4'b0100, 4'b0000));
    mark(90,  mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(100, mkv(4'b0, 1'b0, 4'b0000, 4'b0100));
    sweep(90, 61);
    wr(2, 400, 500, mkv(4'b0, 1'b0, 4'b0100, 4'b0100));
    mark(300, mkv(4'b0, 1'b0, 4'b0100, 4'b0000));
    mark(301, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(400, mkv(4'b0, 1'b0, 4'b0000, 4'b0100));
    mark(500, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(151, 370);

    // ch3: rejected writes leave shadow and pending untouched
    @(negedge clk); ch_ena = 4'b1000;
    wr(3, 20, 40,   mkv(4'b0, 1'b0, 4'b1000, 4'b0000));
    wr(3, 3840, 30, mkv(4'b0, 1'b1, 4'b1000, 4'b0000));
    wr(3, 30, 3840, mkv(4'b0, 1'b1, 4'b1000, 4'b0000));
    mark(0,  mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(20, mkv(4'b0, 1'b0, 4'b0000, 4'b1000));
    mark(40, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(0, 51);

    // hwag_start drop mid-dwell, resume at next set angle
    mark(20, mkv(4'b0, 1'b0, 4'b0000, 4'b1000));
    sweep(0, 31);
    @(negedge clk);
    hwag_start = 1'b0;
    k = cyc;
    expect_at(k + 1, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    repeat (3) @(negedge clk);
    hwag_start = 1'b1;
    sweep(31, 15);
    mark(20, mkv(4'b0, 1'b0, 4'b0000, 4'b1000));
    mark(40, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(0, 46);

    // write and commit in the same cycle: commit uses the old shadow, pending stays
    wr(3, 60, 90, mkv(4'b0, 1'b0, 4'b1000, 4'b0000));
    @(negedge clk);
    acnt = AW'(60); acnt_step = 1'b1;
    wr_bus.wr_ena = 1'b1; wr_bus.wr_ch = 2'd3; wr_bus.wr_set = AW'(70); wr_bus.wr_reset = AW'(80);
    k = cyc;
    expect_at(k + 1, mkv(4'b0, 1'b0, 4'b1000, 4'b1000));
    @(negedge clk);
    acnt_step = 1'b0; wr_bus.wr_ena = 1'b0;
    repeat (2) @(negedge clk);
    mark(90, mkv(4'b0, 1'b0, 4'b1000, 4'b0000));
    mark(91, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(61, 31);
    mark(70, mkv(4'b0, 1'b0, 4'b0000, 4'b1000));
    mark(80, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(60, 25);

    // top angle is a legal set angle; dwell wraps to reset 2
    wr(3, TOP, 2, mkv(4'b0, 1'b0, 4'b1000, 4'b0000));
    mark(3838, mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    mark(TOP,  mkv(4'b0, 1'b0, 4'b0000, 4'b1000));
    mark(2,    mkv(4'b0, 1'b0, 4'b0000, 4'b0000));
    sweep(3838, 6);

`ifdef HWAG_DWELL_LIMIT_EN
    // dwell limit 10: coil high 11 clocks, one overrun pulse
    @(negedge clk); ch_ena = 4'b0001; dwell_max = TW'(10);
    wr(0, 0, 3000, mkv(4'b0, 1'b0, 4'b0001, 4'b0000));
    @(negedge clk);
    acnt = AW'(0); acnt_step = 1'b1;
    k = cyc;
    expect_at(k + 1,  mkv(4'b0000, 1'b0, 4'b0000, 4'b0001));
    expect_at(k + 12, mkv(4'b0001, 1'b0, 4'b0000, 4'b0000));
    expect_at(k + 13, mkv(4'b0000, 1'b0, 4'b0000, 4'b0000));
    @(negedge clk);
    acnt_step = 1'b0;
    repeat (20) @(negedge clk);
`endif

    repeat (10) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || marks.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d events and %0d marks outstanding, required 0", exp_q.size(), marks.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
